// File: rtl/uart_rx_cfg.sv
// UART receiver: configurable width/parity/stop bits, majority-vote sampling, break detection and a FWFT output FIFO.
// States: IDLE wait for edge | START verify start bit | DATA shift bits | PARITY check | STOP check and push | BRK wait for line high
module uart_rx_cfg #(
    parameter int CLK_F      = 50000000,
    parameter int UART_B     = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_perr,
    output logic                          m_ferr,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          overrun,
    output logic                          break_det,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BAUD_CNT_MAX = CLK_F / UART_B;
    localparam int CW = $clog2(BAUD_CNT_MAX);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = DATA_BITS + 2;
    localparam logic [CW-1:0] SAMPLE_PT = CW'(BAUD_CNT_MAX / 2);
    localparam logic [CW-1:0] BIT_END   = CW'(BAUD_CNT_MAX - 1);
    localparam logic          PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK} state_t;

    state_t                state;
    logic                  rx_s1, rx_s2;
    logic [2:0]            hist;
    logic                  smp, fall;
    logic [CW-1:0]         cnt;
    logic [3:0]            bit_idx;
    logic                  stop_idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  perr, ferr, par_smp;
    logic                  at_smp, at_end, last_stop, ferr_final, is_break, push;
    logic [WW-1:0]         push_word;

    logic [WW-1:0]         mem [FIFO_DEPTH];
    logic [LW-1:0]         wr_ptr, rd_ptr;
    logic                  full, empty, pop, do_push;
    logic [WW-1:0]         head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            hist  <= 3'b111;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            hist  <= {hist[1:0], rx_s2};
        end
    end

    always_comb begin
        smp        = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
        fall       = hist[0] & ~rx_s2;
        at_smp     = (cnt == SAMPLE_PT);
        at_end     = (cnt == BIT_END);
        last_stop  = (state == S_STOP) && at_smp && (stop_idx == 1'(STOP_BITS - 1));
        ferr_final = ferr | ~smp;
        is_break   = (shreg == '0) && !par_smp && ferr_final;
        push       = last_stop && !is_break;
        push_word  = {perr, ferr_final, shreg};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            par_smp   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            break_det <= 1'b0;
            if (state != S_IDLE)
                cnt <= at_end ? '0 : cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                        par_smp  <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (at_smp && smp)
                        state <= S_IDLE;
                    else if (at_end)
                        state <= S_DATA;
                end
                S_DATA: begin
                    if (at_smp) begin
                        shreg   <= {smp, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                    if (at_end && bit_idx == 4'(DATA_BITS))
                        state <= (PARITY != 0) ? S_PARITY : S_STOP;
                end
                S_PARITY: begin
                    if (at_smp) begin
                        perr    <= ((^shreg) ^ smp) != PAR_ODD;
                        par_smp <= smp;
                    end
                    if (at_end)
                        state <= S_STOP;
                end
                S_STOP: begin
                    // frame closes at the last stop sample so the next start edge is caught early
                    if (last_stop) begin
                        if (is_break) begin
                            break_det <= 1'b1;
                            state     <= S_BRK;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (at_smp) begin
                        ferr <= ferr_final;
                    end
                    if (at_end)
                        stop_idx <= 1'b1;
                end
                S_BRK: begin
                    if (rx_s2)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop     = !empty && m_ready;
        do_push = push && (!full || pop);
        head    = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            overrun <= push && full && !pop;
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_word;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign m_valid    = !empty;
    assign m_data     = head[DATA_BITS-1:0];
    assign m_ferr     = head[DATA_BITS];
    assign m_perr     = head[DATA_BITS+1];
    assign fifo_level = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 8O2) at 10 clocks per bit.
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    logic rst_n;
    logic rx_line;
    int   sel;
    logic ready_a, ready_e, ready_o;
    logic rx_a, rx_e, rx_o;

    logic [7:0] a_data, e_data, o_data;
    logic a_perr, a_ferr, a_valid, a_ovr, a_brk;
    logic e_perr, e_ferr, e_valid, e_ovr, e_brk;
    logic o_perr, o_ferr, o_valid, o_ovr, o_brk;
    logic [2:0] a_lvl, e_lvl, o_lvl;

    int n_checks = 0;
    int n_fail   = 0;
    int pops_a = 0, ovr_a = 0, brk_a = 0, vcyc_a = 0;
    logic [9:0] last_a = '0;
    int p0, o0, b0, v0;

    always #5 clk = ~clk;

    assign rx_a = (sel == 0) ? rx_line : 1'b1;
    assign rx_e = (sel == 1) ? rx_line : 1'b1;
    assign rx_o = (sel == 2) ? rx_line : 1'b1;

    uart_rx_cfg #(.CLK_F(1000000), .UART_B(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .m_data(a_data), .m_perr(a_perr), .m_ferr(a_ferr),
        .m_valid(a_valid), .m_ready(ready_a), .overrun(a_ovr), .break_det(a_brk), .fifo_level(a_lvl));

    uart_rx_cfg #(.CLK_F(1000000), .UART_B(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
        .clk(clk), .rst_n(rst_n), .rx(rx_e), .m_data(e_data), .m_perr(e_perr), .m_ferr(e_ferr),
        .m_valid(e_valid), .m_ready(ready_e), .overrun(e_ovr), .break_det(e_brk), .fifo_level(e_lvl));

    uart_rx_cfg #(.CLK_F(1000000), .UART_B(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_o (
        .clk(clk), .rst_n(rst_n), .rx(rx_o), .m_data(o_data), .m_perr(o_perr), .m_ferr(o_ferr),
        .m_valid(o_valid), .m_ready(ready_o), .overrun(o_ovr), .break_det(o_brk), .fifo_level(o_lvl));

    always @(posedge clk) begin
        if (a_valid && ready_a) begin
            pops_a++;
            last_a = {a_perr, a_ferr, a_data};
        end
        if (a_ovr)   ovr_a++;
        if (a_brk)   brk_a++;
        if (a_valid) vcyc_a++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // v holds the whole frame LSB first (start bit in v[0]); gbit inverts one clock of that bit
    task automatic send_raw(input logic [15:0] v, input int n, input int gbit);
        for (int i = 0; i < n; i++)
            for (int c = 0; c < 10; c++) begin
                rx_line = (i == gbit && c == 4) ? ~v[i] : v[i];
                @(negedge clk);
            end
        rx_line = 1'b1;
    endtask

    task automatic send_8n1(input logic [7:0] d);
        send_raw({6'b0, 1'b1, d, 1'b0}, 10, -1);
    endtask

    initial begin
        rst_n = 1'b0; rx_line = 1'b1; sel = 0;
        ready_a = 1'b0; ready_e = 1'b0; ready_o = 1'b0;
        idle(3);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_data",  32'(a_data),  32'd0);
        chk("rst_perr",  32'(a_perr),  32'd0);
        chk("rst_ferr",  32'(a_ferr),  32'd0);
        chk("rst_ovr",   32'(a_ovr),   32'd0);
        chk("rst_brk",   32'(a_brk),   32'd0);
        chk("rst_level", 32'(a_lvl),   32'd0);
        rst_n = 1'b1;
        idle(5);

        // 8N1 0xA5 with consumer ready
        ready_a = 1'b1; p0 = pops_a; v0 = vcyc_a;
        send_8n1(8'hA5); idle(5);
        chk("a5_pops",   32'(pops_a - p0), 32'd1);
        chk("a5_word",   32'(last_a),      32'h0A5);
        chk("a5_vcyc",   32'(vcyc_a - v0), 32'd1);
        chk("a5_level",  32'(a_lvl),       32'd0);

        // even parity
        sel = 1;
        send_raw({5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, -1); idle(3);
        chk("e_valid1", 32'(e_valid), 32'd1);
        chk("e_data1",  32'(e_data),  32'h03);
        chk("e_perr1",  32'(e_perr),  32'd1);
        chk("e_ferr1",  32'(e_ferr),  32'd0);
        ready_e = 1'b1; @(negedge clk); ready_e = 1'b0;
        send_raw({5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, -1); idle(3);
        chk("e_data0",  32'(e_data),  32'h03);
        chk("e_perr0",  32'(e_perr),  32'd0);
        ready_e = 1'b1; @(negedge clk); ready_e = 1'b0;
        idle(1);
        chk("e_level",  32'(e_lvl),   32'd0);

        // odd parity, two stop bits
        sel = 2;
        send_raw({4'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0}, 12, -1); idle(3);
        chk("o_data",   32'(o_data),  32'h03);
        chk("o_perr",   32'(o_perr),  32'd0);
        chk("o_ferr",   32'(o_ferr),  32'd0);
        ready_o = 1'b1; @(negedge clk); ready_o = 1'b0;
        send_raw({4'b0, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b0}, 12, -1); idle(3);
        chk("o2_data",  32'(o_data),  32'h7E);
        chk("o2_ferr",  32'(o_ferr),  32'd1);
        chk("o2_perr",  32'(o_perr),  32'd0);
        ready_o = 1'b1; @(negedge clk); ready_o = 1'b0;
        send_raw({4'b0, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b0}, 12, 2); idle(3);
        chk("glitch_data", 32'(o_data), 32'h7E);
        chk("glitch_ferr", 32'(o_ferr), 32'd0);
        ready_o = 1'b1; @(negedge clk); ready_o = 1'b0;
        sel = 0;
        idle(5);

        // false start then valid frame
        p0 = pops_a;
        rx_line = 1'b0; idle(3); rx_line = 1'b1; idle(30);
        chk("fs_pops",  32'(pops_a - p0), 32'd0);
        chk("fs_level", 32'(a_lvl),       32'd0);
        send_8n1(8'h3C); idle(5);
        chk("fs_pops2", 32'(pops_a - p0), 32'd1);
        chk("fs_word",  32'(last_a),      32'h03C);

        // overrun: five frames into a depth-4 FIFO
        ready_a = 1'b0; o0 = ovr_a;
        for (int i = 1; i <= 5; i++) send_8n1(8'(i));
        idle(3);
        chk("ovr_level", 32'(a_lvl),      32'd4);
        chk("ovr_count", 32'(ovr_a - o0), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovr_head", 32'(a_data), 32'(i));
            ready_a = 1'b1; @(negedge clk); ready_a = 1'b0;
        end
        chk("ovr_drained", 32'(a_lvl), 32'd0);

        // simultaneous push and pop when full
        o0 = ovr_a;
        for (int i = 1; i <= 4; i++) send_8n1(8'(i));
        fork
            send_8n1(8'h05);
            begin
                repeat (98) @(negedge clk);
                ready_a = 1'b1;
                @(negedge clk);
                ready_a = 1'b0;
            end
        join
        idle(3);
        chk("pp_count", 32'(ovr_a - o0), 32'd0);
        chk("pp_level", 32'(a_lvl),      32'd4);
        for (int i = 2; i <= 5; i++) begin
            chk("pp_head", 32'(a_data), 32'(i));
            ready_a = 1'b1; @(negedge clk); ready_a = 1'b0;
        end
        chk("pp_drained", 32'(a_lvl), 32'd0);

        // break
        ready_a = 1'b1; p0 = pops_a; b0 = brk_a;
        rx_line = 1'b0; idle(300); rx_line = 1'b1; idle(30);
        chk("brk_count", 32'(brk_a - b0), 32'd1);
        chk("brk_pops",  32'(pops_a - p0), 32'd0);
        send_8n1(8'h5A); idle(5);
        chk("brk_pops2", 32'(pops_a - p0), 32'd1);
        chk("brk_word",  32'(last_a),      32'h05A);

        // reset mid-frame with a word already queued
        ready_a = 1'b0;
        send_8n1(8'h11); idle(3);
        chk("pre_rst_valid", 32'(a_valid), 32'd1);
        p0 = pops_a; b0 = brk_a; o0 = ovr_a;
        fork
            send_8n1(8'h5A);
            begin
                repeat (40) @(negedge clk);
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                chk("mr_valid", 32'(a_valid), 32'd0);
                chk("mr_data",  32'(a_data),  32'd0);
                chk("mr_flags", 32'({a_perr, a_ferr, a_ovr, a_brk}), 32'd0);
                chk("mr_level", 32'(a_lvl),   32'd0);
            end
        join
        rst_n = 1'b1;
        ready_a = 1'b1;
        idle(150);
        chk("mr_pops",  32'(pops_a - p0), 32'd0);
        chk("mr_valid2", 32'(a_valid),    32'd0);
        chk("mr_pulses", 32'((brk_a - b0) + (ovr_a - o0)), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
